serial_add_sequencer: RTL and testbench
=======================================

// Module: serial_add_sequencer
// PURPOSE
//  Bit-serial adder/subtractor controller. Time-multiplexes one 1-bit full-adder cell
//  (two half adders plus an OR on the carries) across all operand bits, one bit per clock.
//  Sits beside the ALU as a low-area add/sub path. Uses a START/BUSY/DONE handshake
//  and a carry flip-flop between bit steps.
// PARAMETERS
//  WIDTH    32   operand/result width in bits (>=1)
//  CNT_W    6    bit-counter width, >= clog2(WIDTH+1)
// PORTS
//  CLK    in   1      system clock, rising edge
//  RST    in   1      synchronous reset, active-high
//  START  in   1      request; sampled only in IDLE
//  SUB    in   1      0 = A+B, 1 = A-B; captured with START
//  A      in   WIDTH  operand A; captured with START
//  B      in   WIDTH  operand B; captured with START
//  BUSY   out  1      high in RUN and DONE states
//  DONE   out  1      one-cycle pulse; SUM/CO/OVF valid from this cycle
//  SUM    out  WIDTH  result, held until next accepted START
//  CO     out  1      final carry out (SUB: 1 = no borrow)
//  OVF    out  1      signed overflow = carry into MSB XOR carry out of MSB
// BEHAVIOUR
//  - Reset (RST=1 at edge): state=IDLE, BUSY=0, DONE=0, SUM=0, CO=0, OVF=0, counter=0,
//    carry FF=0. Takes priority over everything, including mid-operation: the in-flight op
//    is dropped and no DONE is issued.
//  - FSM states: IDLE -> RUN -> DONE -> IDLE.
//  - IDLE: if START=1 at edge, load opA<=A, opB<=(SUB ? ~B : B), carry<=SUB, cnt<=0,
//    SUM<=0, goto RUN. Otherwise hold state.
//  - RUN: each edge, full-adder(opA[0], opB[0], carry) -> s, c.
//    Shift s into SUM from the MSB side (SUM <= {s, SUM[WIDTH-1:1]}).
//    Shift opA and opB right by 1; carry<=c; cnt<=cnt+1.
//  - RUN to DONE: on the edge where cnt==WIDTH-1, after that bit is processed.
//    On that edge also set CO<=c and OVF<=c XOR carry_in_of_that_bit.
//  - DONE: DONE=1 for exactly one cycle, BUSY=1. Next edge goes to IDLE.
//    START is not accepted in DONE.
//  - Latency: START sampled at edge k; DONE is high in the cycle after edge k+WIDTH.
//    The next START can be accepted at edge k+WIDTH+2.
//  - START while BUSY=1: ignored, with no queuing; A/B/SUB changes have no effect.
//  - Arithmetic is modulo 2^WIDTH; SUM wraps and CO captures the carry.
//  - WIDTH=1: one RUN cycle; OVF = carry-in XOR carry-out of bit 0.
//  - Outputs are registered; no combinational path from inputs to outputs.
// STRUCTURE
//  - prj_definition.v holds the shared state encodings (SAS_IDLE=2'b00, SAS_RUN=2'b01,
//    SAS_DONE=2'b10) and the default data width.
//  - Sub-module FULL_ADDER_1BIT(S,CO,A,B,CI): two HALF_ADDER instances, carries ORed.
//    Instantiated once; this block owns all sequencing and state.
// TESTING (WIDTH=32)
//  1. A=5, B=3, SUB=0, START pulse -> DONE after 33 edges; SUM=0x00000008, CO=0, OVF=0.
//  2. A=0xFFFFFFFF, B=1, SUB=0 -> SUM=0x00000000, CO=1, OVF=0.
//  3. A=0x7FFFFFFF, B=1, SUB=0 -> SUM=0x80000000, CO=0, OVF=1.
//  4. A=5, B=7, SUB=1 -> SUM=0xFFFFFFFE, CO=0, OVF=0.
//     A=7, B=5, SUB=1 -> SUM=0x00000002, CO=1.
//  5. START again with A=9 at RUN cycle 5 -> ignored. Exactly one DONE, with the
//     original result; DONE lasts 1 cycle, BUSY falls with it.
//  6. RST=1 at RUN cycle 10 -> next cycle BUSY=0, DONE=0, SUM=0, state IDLE, and no
//     DONE follows. A new START then completes normally.

Source files
------------

// File: rtl/serial_add_sequencer_pkg.sv
// Shared definitions for the bit-serial add/sub sequencer: state encodings,
// default sizing and the signed-overflow helper.
package serial_add_sequencer_pkg;

    localparam int SAS_DEFAULT_WIDTH = 32;
    localparam int SAS_DEFAULT_CNT_W = 6;

    typedef enum logic [1:0] {
        SAS_IDLE = 2'b00,
        SAS_RUN  = 2'b01,
        SAS_DONE = 2'b10
    } sas_state_t;

    // Signed overflow of a two's complement add is the disagreement between
    // the carry entering the MSB and the carry leaving it.
    function automatic logic sas_overflow(input logic carry_into_msb, input logic carry_out_msb);
        return carry_into_msb ^ carry_out_msb;
    endfunction

endpackage

// File: rtl/serial_add_sequencer_if.sv
// Request/result bundle between a client and the serial add/sub sequencer.
// The client (master) drives the operands and start strobe; the sequencer
// (slave) returns status and the registered result.
interface serial_add_sequencer_if
    import serial_add_sequencer_pkg::*;
#(
    parameter int WIDTH = SAS_DEFAULT_WIDTH
);

    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             co;
    logic             ovf;

    modport master (
        output start, sub, a, b,
        input  busy, done, sum, co, ovf
    );

    modport slave (
        input  start, sub, a, b,
        output busy, done, sum, co, ovf
    );

endinterface

// File: rtl/serial_add_sequencer_full_adder.sv
// One-bit full adder built from two half adders with their carries ORed.
// This is the single arithmetic cell the sequencer reuses on every bit step.
module half_adder (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);

    assign s = a ^ b;
    assign c = a & b;

endmodule

module full_adder_1bit (
    output logic s,
    output logic co,
    input  logic a,
    input  logic b,
    input  logic ci
);

    logic s1;
    logic c1;
    logic c2;

    half_adder u_ha0 (
        .a (a),
        .b (b),
        .s (s1),
        .c (c1)
    );

    half_adder u_ha1 (
        .a (s1),
        .b (ci),
        .s (s),
        .c (c2)
    );

    assign co = c1 | c2;

endmodule

// File: rtl/serial_add_sequencer.sv
// Bit-serial adder/subtractor. Operands are captured on an accepted start,
// then one bit per clock passes through a shared full-adder cell, LSB first,
// with the carry held in a flip-flop between steps. The result bits enter the
// sum register from the MSB side so that after WIDTH steps the word is aligned.
// Subtraction is A + ~B + 1, the +1 coming from the preset carry.
module serial_add_sequencer
    import serial_add_sequencer_pkg::*;
#(
    parameter int WIDTH = SAS_DEFAULT_WIDTH,
    parameter int CNT_W = SAS_DEFAULT_CNT_W
) (
    input logic                  clk,
    input logic                  rst,
    serial_add_sequencer_if.slave bus
);

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    sas_state_t       state;
    sas_state_t       state_n;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_a_n;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] op_b_n;
    logic             carry;
    logic             carry_n;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_n;
    logic [WIDTH-1:0] sum_q;
    logic [WIDTH-1:0] sum_n;
    logic             co_q;
    logic             co_n;
    logic             ovf_q;
    logic             ovf_n;

    logic             fa_s;
    logic             fa_c;

    full_adder_1bit u_fa (
        .s  (fa_s),
        .co (fa_c),
        .a  (op_a[0]),
        .b  (op_b[0]),
        .ci (carry)
    );

    // State and datapath registers; reset abandons any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= SAS_IDLE;
            op_a  <= '0;
            op_b  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum_q <= '0;
            co_q  <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            state <= state_n;
            op_a  <= op_a_n;
            op_b  <= op_b_n;
            carry <= carry_n;
            cnt   <= cnt_n;
            sum_q <= sum_n;
            co_q  <= co_n;
            ovf_q <= ovf_n;
        end
    end

    // Next-state and datapath update: capture in IDLE, one bit per cycle in RUN,
    // a single cycle of DONE before returning to IDLE.
    always_comb begin
        state_n = state;
        op_a_n  = op_a;
        op_b_n  = op_b;
        carry_n = carry;
        cnt_n   = cnt;
        sum_n   = sum_q;
        co_n    = co_q;
        ovf_n   = ovf_q;

        case (state)
            SAS_IDLE: begin
                if (bus.start) begin
                    op_a_n  = bus.a;
                    op_b_n  = bus.sub ? ~bus.b : bus.b;
                    carry_n = bus.sub;
                    cnt_n   = '0;
                    sum_n   = '0;
                    state_n = SAS_RUN;
                end
            end
            SAS_RUN: begin
                sum_n   = (sum_q >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));
                op_a_n  = op_a >> 1;
                op_b_n  = op_b >> 1;
                carry_n = fa_c;
                cnt_n   = cnt + CNT_W'(1);
                if (cnt == LAST_BIT) begin
                    co_n    = fa_c;
                    ovf_n   = sas_overflow(carry, fa_c);
                    state_n = SAS_DONE;
                end
            end
            SAS_DONE: begin
                state_n = SAS_IDLE;
            end
            default: begin
                state_n = SAS_IDLE;
            end
        endcase
    end

    assign bus.busy = (state == SAS_RUN) || (state == SAS_DONE);
    assign bus.done = (state == SAS_DONE);
    assign bus.sum  = sum_q;
    assign bus.co   = co_q;
    assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_serial_add_sequencer.sv
// Self-checking bench for the serial add/sub sequencer at WIDTH=32.
// Expected results come from a word-level arithmetic model, are queued when
// an operation is launched and popped when the DUT raises done.
module tb_serial_add_sequencer;
    import serial_add_sequencer_pkg::*;

    localparam int WIDTH = 32;
    localparam int CNT_W = 6;
    localparam int TIMEOUT = 100;

    typedef struct packed {
        logic [WIDTH-1:0] sum;
        logic             co;
        logic             ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    serial_add_sequencer_if #(.WIDTH(WIDTH)) bus ();

    serial_add_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic sub);
        exp_t e;
        logic [WIDTH:0] full;
        if (!sub) begin
            full  = {1'b0, a} + {1'b0, b};
            e.sum = full[WIDTH-1:0];
            e.co  = full[WIDTH];
            e.ovf = (a[WIDTH-1] == b[WIDTH-1]) && (e.sum[WIDTH-1] != a[WIDTH-1]);
        end else begin
            e.sum = a - b;
            e.co  = (a >= b);
            e.ovf = (a[WIDTH-1] != b[WIDTH-1]) && (e.sum[WIDTH-1] != a[WIDTH-1]);
        end
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic sub);
        bus.a     = a;
        bus.b     = b;
        bus.sub   = sub;
        bus.start = 1'b1;
        sb.push_back(model(a, b, sub));
        tick();
        bus.start = 1'b0;
    endtask

    task automatic wait_done(output int n, output bit timed_out);
        n = 0;
        while (!bus.done && n < TIMEOUT) begin
            tick();
            n++;
        end
        timed_out = !bus.done;
    endtask

    // Launch one operation, wait for done, capture results and the cycle after.
    task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic sub,
                          output int lat, output bit timed_out, output exp_t got,
                          output logic busy_at_done, output logic done_after, output logic busy_after);
        issue(a, b, sub);
        wait_done(lat, timed_out);
        got.sum      = bus.sum;
        got.co       = bus.co;
        got.ovf      = bus.ovf;
        busy_at_done = bus.busy;
        tick();
        done_after   = bus.done;
        busy_after   = bus.busy;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.sub   = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        tick();
        tick();
        rst = 1'b0;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b want 0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b want 0", bus.done); end
        checks++; if (bus.sum !== '0) begin errors++; $display("[TB] FAIL reset_sum: got %h want 0", bus.sum); end
        checks++; if (bus.co !== 1'b0) begin errors++; $display("[TB] FAIL reset_co: got %b want 0", bus.co); end
        checks++; if (bus.ovf !== 1'b0) begin errors++; $display("[TB] FAIL reset_ovf: got %b want 0", bus.ovf); end
        tick();
    endtask

    // Run a list of operations back to back; each starts the cycle after done falls.
    task automatic test_ops(input string name, input logic [WIDTH-1:0] av[], input logic [WIDTH-1:0] bv[], input logic sv[]);
        int   lat;
        bit   to;
        exp_t got;
        exp_t exp;
        logic bd, da, ba;
        for (int i = 0; i < av.size(); i++) begin
            run_op(av[i], bv[i], sv[i], lat, to, got, bd, da, ba);
            exp = sb.pop_front();
            checks++;
            if (to) begin
                errors++;
                $display("[TB] FAIL %s[%0d]_timeout: no done within %0d cycles", name, i, TIMEOUT);
                continue;
            end
            checks++; if (lat !== WIDTH) begin errors++; $display("[TB] FAIL %s[%0d]_latency: got %0d want %0d", name, i, lat, WIDTH); end
            checks++; if (got.sum !== exp.sum) begin errors++; $display("[TB] FAIL %s[%0d]_sum: got %h want %h", name, i, got.sum, exp.sum); end
            checks++; if (got.co !== exp.co) begin errors++; $display("[TB] FAIL %s[%0d]_co: got %b want %b", name, i, got.co, exp.co); end
            checks++; if (got.ovf !== exp.ovf) begin errors++; $display("[TB] FAIL %s[%0d]_ovf: got %b want %b", name, i, got.ovf, exp.ovf); end
            checks++; if (bd !== 1'b1) begin errors++; $display("[TB] FAIL %s[%0d]_busy_in_done: got %b want 1", name, i, bd); end
            checks++; if (da !== 1'b0) begin errors++; $display("[TB] FAIL %s[%0d]_done_one_cycle: got %b want 0", name, i, da); end
            checks++; if (ba !== 1'b0) begin errors++; $display("[TB] FAIL %s[%0d]_busy_falls: got %b want 0", name, i, ba); end
        end
    endtask

    task automatic test_add();
        logic [WIDTH-1:0] av[] = '{32'd5, 32'hFFFF_FFFF, 32'h7FFF_FFFF};
        logic [WIDTH-1:0] bv[] = '{32'd3, 32'd1, 32'd1};
        logic             sv[] = '{1'b0, 1'b0, 1'b0};
        test_ops("add", av, bv, sv);
    endtask

    task automatic test_sub();
        logic [WIDTH-1:0] av[] = '{32'd5, 32'd7, 32'h8000_0000, 32'd0};
        logic [WIDTH-1:0] bv[] = '{32'd7, 32'd5, 32'd1, 32'd0};
        logic             sv[] = '{1'b1, 1'b1, 1'b1, 1'b1};
        test_ops("sub", av, bv, sv);
    endtask

    task automatic test_back_to_back();
        logic [WIDTH-1:0] av[] = new[8];
        logic [WIDTH-1:0] bv[] = new[8];
        logic             sv[] = new[8];
        for (int i = 0; i < 8; i++) begin
            av[i] = $urandom();
            bv[i] = $urandom();
            sv[i] = 1'($urandom_range(1, 0));
        end
        test_ops("b2b", av, bv, sv);
    endtask

    task automatic test_start_while_busy();
        int   n;
        bit   to;
        int   extra_done;
        exp_t exp;
        issue(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        repeat (4) tick();
        bus.a     = 32'd9;
        bus.b     = 32'd9;
        bus.sub   = 1'b1;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        wait_done(n, to);
        exp = sb.pop_front();
        checks++;
        if (to) begin
            errors++;
            $display("[TB] FAIL busy_start_timeout: no done within %0d cycles", TIMEOUT);
        end else begin
            checks++; if (n + 5 !== WIDTH) begin errors++; $display("[TB] FAIL busy_start_latency: got %0d want %0d", n + 5, WIDTH); end
            checks++; if (bus.sum !== exp.sum) begin errors++; $display("[TB] FAIL busy_start_sum: got %h want %h", bus.sum, exp.sum); end
            checks++; if (bus.co !== exp.co) begin errors++; $display("[TB] FAIL busy_start_co: got %b want %b", bus.co, exp.co); end
            checks++; if (bus.ovf !== exp.ovf) begin errors++; $display("[TB] FAIL busy_start_ovf: got %b want %b", bus.ovf, exp.ovf); end
            tick();
            checks++; if (bus.done !== 1'b0) begin errors++; $display("[TB] FAIL busy_start_done_width: got %b want 0", bus.done); end
            checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL busy_start_busy_falls: got %b want 0", bus.busy); end
        end
        extra_done = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus.done) extra_done++;
        end
        checks++; if (extra_done !== 0) begin errors++; $display("[TB] FAIL busy_start_single_done: got %0d extra dones want 0", extra_done); end
    endtask

    task automatic test_reset_mid_op();
        int extra_done;
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        void'(sb.pop_back());
        repeat (9) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL midrst_busy: got %b want 0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("[TB] FAIL midrst_done: got %b want 0", bus.done); end
        checks++; if (bus.sum !== '0) begin errors++; $display("[TB] FAIL midrst_sum: got %h want 0", bus.sum); end
        checks++; if (bus.co !== 1'b0) begin errors++; $display("[TB] FAIL midrst_co: got %b want 0", bus.co); end
        extra_done = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus.done || bus.busy) extra_done++;
        end
        checks++; if (extra_done !== 0) begin errors++; $display("[TB] FAIL midrst_no_done: got %0d busy/done cycles want 0", extra_done); end
    endtask

    task automatic test_after_reset();
        logic [WIDTH-1:0] av[] = '{32'd12345};
        logic [WIDTH-1:0] bv[] = '{32'd54321};
        logic             sv[] = '{1'b0};
        test_ops("post_rst", av, bv, sv);
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_start_while_busy();
        test_reset_mid_op();
        test_after_reset();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
